pipeline_controller: RTL and testbench

//  Central stall/flush sequencer for the 4-stage core (fetch, decode, execute, memory/write-back).

---
 rtl/kasirga_pipe_pkg.sv | 22 ++
 rtl/pipeline_controller_trap_priority_encoder.sv | 46 ++++
 rtl/pipeline_controller.sv | 196 +++++++++++++++++++
 tb/tb_pipeline_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/kasirga_pipe_pkg.sv
// Shared definitions for the pipeline controller: trap cause codes and the
// sequencer state encoding.
package kasirga_pipe_pkg;

  typedef enum logic [2:0] {
    CAUSE_ILLEGAL          = 3'd0,
    CAUSE_BREAKPOINT       = 3'd1,
    CAUSE_ECALL_M          = 3'd2,
    CAUSE_LOAD_MISALIGNED  = 3'd3,
    CAUSE_STORE_MISALIGNED = 3'd4
  } exc_cause_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } pipe_state_e;

  localparam int REDIRECT_CNT_W = 3;

endpackage

// File: rtl/pipeline_controller_trap_priority_encoder.sv
// Combinational trap source select. Memory-stage exceptions belong to the
// oldest instruction and win over decode; within each stage the fixed order is
// store > load and illegal > breakpoint > ecall.
module trap_priority_encoder
  import kasirga_pipe_pkg::*;
(
  input  logic        i_dec_illegal,
  input  logic        i_dec_breakpoint,
  input  logic        i_dec_ecall,
  input  logic [31:0] i_dec_pc,
  input  logic        i_mem_load_misaligned,
  input  logic        i_mem_store_misaligned,
  input  logic [31:0] i_mem_pc,
  input  logic [31:0] i_mem_addr,
  output logic        o_mem_exc,
  output logic        o_dec_exc,
  output exc_cause_e  o_cause,
  output logic [31:0] o_pc,
  output logic [31:0] o_addr
);

  // Select cause, mepc and mtval of the highest-priority pending exception.
  always_comb begin
    o_mem_exc = i_mem_store_misaligned | i_mem_load_misaligned;
    o_dec_exc = i_dec_illegal | i_dec_breakpoint | i_dec_ecall;
    o_cause   = CAUSE_ILLEGAL;
    o_pc      = i_dec_pc;
    o_addr    = 32'd0;
    if (i_mem_store_misaligned) begin
      o_cause = CAUSE_STORE_MISALIGNED;
      o_pc    = i_mem_pc;
      o_addr  = i_mem_addr;
    end else if (i_mem_load_misaligned) begin
      o_cause = CAUSE_LOAD_MISALIGNED;
      o_pc    = i_mem_pc;
      o_addr  = i_mem_addr;
    end else if (i_dec_illegal) begin
      o_cause = CAUSE_ILLEGAL;
    end else if (i_dec_breakpoint) begin
      o_cause = CAUSE_BREAKPOINT;
    end else if (i_dec_ecall) begin
      o_cause = CAUSE_ECALL_M;
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 4-stage core. Merges stage stall requests,
// mispredicts, mret and exceptions into per-stage stall/flush, and serialises
// trap entry towards the CSR file.
// Optional build macro PIPE_CTRL_PERF_EN adds stall-cycle and trap counters.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_RUN      | normal flow; stalls/flushes derived from inputs
// ST_DRAIN    | trap captured, waiting for the memory stage to go idle
// ST_COMMIT   | one-cycle en_exception_o pulse with the captured fields
// ST_REDIRECT | fetch/decode held flushed while the trap vector is fetched
module pipeline_controller
  import kasirga_pipe_pkg::*;
#(
  parameter int REDIRECT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        decode_stall_req_i,
  input  logic        exec_busy_i,
  input  logic        mem_busy_i,
  input  logic        branch_mispredict_i,
  input  logic        mret_i,
  input  logic        dec_illegal_i,
  input  logic        dec_breakpoint_i,
  input  logic        dec_ecall_i,
  input  logic [31:0] dec_pc_i,
  input  logic        mem_load_misaligned_i,
  input  logic        mem_store_misaligned_i,
  input  logic [31:0] mem_pc_i,
  input  logic [31:0] mem_addr_i,
  output logic        stall_fetch_o,
  output logic        stall_decode_o,
  output logic        stall_exec_o,
  output logic        stall_mem_o,
  output logic        flush_fetch_o,
  output logic        flush_decode_o,
  output logic        flush_exec_o,
  output logic        en_exception_o,
  output logic [2:0]  exception_cause_o,
  output logic [31:0] exception_adress_o,
  output logic [31:0] exception_program_counter_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles_o,
  output logic [15:0] perf_trap_count_o
`endif
);

  localparam logic [REDIRECT_CNT_W-1:0] REDIRECT_LOAD = REDIRECT_CNT_W'(REDIRECT_CYCLES);

  pipe_state_e                r_state;
  pipe_state_e                w_next_state;
  logic [REDIRECT_CNT_W-1:0]  r_cnt;
  logic [REDIRECT_CNT_W-1:0]  w_cnt_next;
  exc_cause_e                 r_cause;
  logic [31:0]                r_pc;
  logic [31:0]                r_addr;

  logic        w_mem_exc;
  logic        w_dec_exc;
  exc_cause_e  w_cause;
  logic [31:0] w_pc;
  logic [31:0] w_addr;
  logic        w_accept;
  logic        w_capture;
  logic        w_misp_flush;
  logic        w_any_stall_req;

  trap_priority_encoder u_trap_enc (
    .i_dec_illegal          (dec_illegal_i),
    .i_dec_breakpoint       (dec_breakpoint_i),
    .i_dec_ecall            (dec_ecall_i),
    .i_dec_pc               (dec_pc_i),
    .i_mem_load_misaligned  (mem_load_misaligned_i),
    .i_mem_store_misaligned (mem_store_misaligned_i),
    .i_mem_pc               (mem_pc_i),
    .i_mem_addr             (mem_addr_i),
    .o_mem_exc              (w_mem_exc),
    .o_dec_exc              (w_dec_exc),
    .o_cause                (w_cause),
    .o_pc                   (w_pc),
    .o_addr                 (w_addr)
  );

  // A decode exception behind a mispredict is on the wrong path and is dropped.
  assign w_accept        = w_mem_exc | (w_dec_exc & ~branch_mispredict_i);
  assign w_any_stall_req = mem_busy_i | exec_busy_i | decode_stall_req_i;

  // Next-state and per-stage stall/flush decode.
  always_comb begin
    w_next_state   = r_state;
    w_cnt_next     = r_cnt;
    w_capture      = 1'b0;
    w_misp_flush   = 1'b0;
    stall_fetch_o  = 1'b0;
    stall_decode_o = 1'b0;
    stall_exec_o   = 1'b0;
    stall_mem_o    = 1'b0;
    flush_fetch_o  = 1'b0;
    flush_decode_o = 1'b0;
    flush_exec_o   = 1'b0;
    en_exception_o = 1'b0;
    case (r_state)
      ST_RUN: begin
        // Mispredict input stays asserted while memory is busy, so it is simply withheld.
        w_misp_flush   = branch_mispredict_i & ~mem_busy_i;
        stall_mem_o    = mem_busy_i;
        stall_exec_o   = mem_busy_i | exec_busy_i;
        stall_decode_o = mem_busy_i | exec_busy_i;
        stall_fetch_o  = mem_busy_i | exec_busy_i | (decode_stall_req_i & ~w_misp_flush);
        if (w_misp_flush) begin
          flush_fetch_o  = 1'b1;
          flush_decode_o = 1'b1;
        end
        if (mret_i && !w_any_stall_req) begin
          flush_fetch_o = 1'b1;
        end
        if (w_accept) begin
          flush_fetch_o  = 1'b1;
          flush_decode_o = 1'b1;
          flush_exec_o   = w_mem_exc;
          w_capture      = 1'b1;
          w_next_state   = mem_busy_i ? ST_DRAIN : ST_COMMIT;
        end
      end
      ST_DRAIN: begin
        stall_fetch_o  = 1'b1;
        flush_fetch_o  = 1'b1;
        flush_decode_o = 1'b1;
        if (!mem_busy_i) begin
          w_next_state = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        en_exception_o = 1'b1;
        w_cnt_next     = REDIRECT_LOAD;
        w_next_state   = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        flush_fetch_o  = 1'b1;
        flush_decode_o = 1'b1;
        w_cnt_next     = r_cnt - 1'b1;
        if (r_cnt <= 1) begin
          w_next_state = ST_RUN;
        end
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  // State, redirect counter and trap capture registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_cause <= CAUSE_ILLEGAL;
      r_pc    <= 32'd0;
      r_addr  <= 32'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (w_capture) begin
        r_cause <= w_cause;
        r_pc    <= w_pc;
        r_addr  <= w_addr;
      end
    end
  end

  assign exception_cause_o           = r_cause;
  assign exception_adress_o          = r_addr;
  assign exception_program_counter_o = r_pc;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [15:0] r_perf_trap;

  // Free-running wrap-around counters of fetch-stall cycles and committed traps.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_perf_stall <= 32'd0;
      r_perf_trap  <= 16'd0;
    end else begin
      if (stall_fetch_o) r_perf_stall <= r_perf_stall + 32'd1;
      if (r_state == ST_COMMIT) r_perf_trap <= r_perf_trap + 16'd1;
    end
  end

  assign perf_stall_cycles_o = r_perf_stall;
  assign perf_trap_count_o   = r_perf_trap;
`else
  // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed-vector bench for pipeline_controller with a queue-based scoreboard.
module tb_pipeline_controller;

  logic        clk_i = 1'b0;
  logic        rst_i, decode_stall_req_i, exec_busy_i, mem_busy_i;
  logic        branch_mispredict_i, mret_i;
  logic        dec_illegal_i, dec_breakpoint_i, dec_ecall_i;
  logic [31:0] dec_pc_i;
  logic        mem_load_misaligned_i, mem_store_misaligned_i;
  logic [31:0] mem_pc_i, mem_addr_i;
  logic        stall_fetch_o, stall_decode_o, stall_exec_o, stall_mem_o;
  logic        flush_fetch_o, flush_decode_o, flush_exec_o, en_exception_o;
  logic [2:0]  exception_cause_o;
  logic [31:0] exception_adress_o, exception_program_counter_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles_o;
  logic [15:0] perf_trap_count_o;
`endif

  always #5 clk_i = ~clk_i;

  pipeline_controller #(.REDIRECT_CYCLES(2)) dut (
    .clk_i                       (clk_i),
    .rst_i                       (rst_i),
    .decode_stall_req_i          (decode_stall_req_i),
    .exec_busy_i                 (exec_busy_i),
    .mem_busy_i                  (mem_busy_i),
    .branch_mispredict_i         (branch_mispredict_i),
    .mret_i                      (mret_i),
    .dec_illegal_i               (dec_illegal_i),
    .dec_breakpoint_i            (dec_breakpoint_i),
    .dec_ecall_i                 (dec_ecall_i),
    .dec_pc_i                    (dec_pc_i),
    .mem_load_misaligned_i       (mem_load_misaligned_i),
    .mem_store_misaligned_i      (mem_store_misaligned_i),
    .mem_pc_i                    (mem_pc_i),
    .mem_addr_i                  (mem_addr_i),
    .stall_fetch_o               (stall_fetch_o),
    .stall_decode_o              (stall_decode_o),
    .stall_exec_o                (stall_exec_o),
    .stall_mem_o                 (stall_mem_o),
    .flush_fetch_o               (flush_fetch_o),
    .flush_decode_o              (flush_decode_o),
    .flush_exec_o                (flush_exec_o),
    .en_exception_o              (en_exception_o),
    .exception_cause_o           (exception_cause_o),
    .exception_adress_o          (exception_adress_o),
    .exception_program_counter_o (exception_program_counter_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles_o         (perf_stall_cycles_o),
    .perf_trap_count_o           (perf_trap_count_o)
`endif
  );

  // input bits: {rst, dstall, exec_busy, mem_busy, mispredict, mret, ill, bp, ecall, ld_mis, st_mis}
  localparam logic [10:0] RSTN = 11'h400, DSR = 11'h200, EXB = 11'h100, MEMB = 11'h080;
  localparam logic [10:0] MISP = 11'h040, MRET = 11'h020, ILL = 11'h010, BP = 11'h008;
  localparam logic [10:0] ECALL = 11'h004, LDM = 11'h002, STM = 11'h001;
  // output bits: {stall f,d,e,m, flush f,d,e, en_exception}
  localparam logic [7:0] SF = 8'h80, SD = 8'h40, SE = 8'h20, SM = 8'h10;
  localparam logic [7:0] FF = 8'h08, FD = 8'h04, FE = 8'h02, EN = 8'h01;

  typedef struct {
    string       name;
    logic [74:0] exp;
  } vec_t;

  vec_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic apply(input string name, input logic [10:0] in,
                       input logic [31:0] dpc, input logic [31:0] mpc, input logic [31:0] maddr,
                       input logic [7:0] ectl, input logic [2:0] ecause,
                       input logic [31:0] epc, input logic [31:0] eaddr);
    vec_t v;
    @(posedge clk_i);
    #1;
    {rst_i, decode_stall_req_i, exec_busy_i, mem_busy_i, branch_mispredict_i, mret_i,
     dec_illegal_i, dec_breakpoint_i, dec_ecall_i,
     mem_load_misaligned_i, mem_store_misaligned_i} = in;
    dec_pc_i   = dpc;
    mem_pc_i   = mpc;
    mem_addr_i = maddr;
    v.name = name;
    v.exp  = {ectl, ecause, epc, eaddr};
    q.push_back(v);
  endtask

  // Two REDIRECT cycles then back in RUN, captured fields held throughout.
  task automatic redirect_run(input string name, input logic [2:0] c,
                              input logic [31:0] pc, input logic [31:0] ad);
    apply({name, "_redir1"}, RSTN, 0, 0, 0, FF | FD, c, pc, ad);
    apply({name, "_redir2"}, RSTN, 0, 0, 0, FF | FD, c, pc, ad);
    apply({name, "_run"},    RSTN, 0, 0, 0, 8'h00,   c, pc, ad);
  endtask

  // Monitor: compares each presented cycle against the queued expectation.
  vec_t        mv;
  logic [74:0] got;
  initial begin
    forever begin
      @(negedge clk_i);
      if (q.size() != 0) begin
        mv  = q.pop_front();
        got = {stall_fetch_o, stall_decode_o, stall_exec_o, stall_mem_o,
               flush_fetch_o, flush_decode_o, flush_exec_o, en_exception_o,
               exception_cause_o, exception_program_counter_o, exception_adress_o};
        n_vec++;
        if (got !== mv.exp) begin
          n_bad++;
          $display("FAIL %s: ctl=%02h cause=%0d pc=%08h addr=%08h, expected ctl=%02h cause=%0d pc=%08h addr=%08h",
                   mv.name, got[74:67], got[66:64], got[63:32], got[31:0],
                   mv.exp[74:67], mv.exp[66:64], mv.exp[63:32], mv.exp[31:0]);
        end
      end
    end
  end

  initial begin
    {rst_i, decode_stall_req_i, exec_busy_i, mem_busy_i, branch_mispredict_i, mret_i,
     dec_illegal_i, dec_breakpoint_i, dec_ecall_i,
     mem_load_misaligned_i, mem_store_misaligned_i} = '0;
    dec_pc_i = 0; mem_pc_i = 0; mem_addr_i = 0;
    repeat (2) @(posedge clk_i);

    apply("reset", 11'h000, 0, 0, 0, 8'h00, 0, 0, 0);
    apply("idle",  RSTN,    0, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      apply("exec_busy", RSTN | EXB, 0, 0, 0, SF | SD | SE, 0, 0, 0);
    apply("exec_release", RSTN, 0, 0, 0, 8'h00, 0, 0, 0);
    apply("dec_stall", RSTN | DSR, 0, 0, 0, SF, 0, 0, 0);
    apply("mem_busy", RSTN | MEMB, 0, 0, 0, SF | SD | SE | SM, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      apply("misp_held", RSTN | MISP | MEMB, 0, 0, 0, SF | SD | SE | SM, 0, 0, 0);
    apply("misp_release", RSTN | MISP, 0, 0, 0, FF | FD, 0, 0, 0);
    apply("misp_done", RSTN, 0, 0, 0, 8'h00, 0, 0, 0);
    apply("misp_over_dstall", RSTN | MISP | DSR, 0, 0, 0, FF | FD, 0, 0, 0);
    apply("mret", RSTN | MRET, 0, 0, 0, FF, 0, 0, 0);
    apply("mret_stalled", RSTN | MRET | DSR, 0, 0, 0, SF, 0, 0, 0);

    apply("ecall_accept", RSTN | ECALL, 32'h80, 0, 0, FF | FD, 0, 0, 0);
    apply("ecall_commit", RSTN, 0, 0, 0, EN, 3'd2, 32'h80, 0);
    apply("ecall_redir1_ignore", RSTN | ILL | MISP, 32'h44, 0, 0, FF | FD, 3'd2, 32'h80, 0);
    apply("ecall_redir2", RSTN, 0, 0, 0, FF | FD, 3'd2, 32'h80, 0);
    apply("ecall_run", RSTN, 0, 0, 0, 8'h00, 3'd2, 32'h80, 0);

    apply("store_vs_ill", RSTN | ILL | STM, 32'h44, 32'h200, 32'h1003, FF | FD | FE, 3'd2, 32'h80, 0);
    apply("store_commit", RSTN, 0, 0, 0, EN, 3'd4, 32'h200, 32'h1003);
    redirect_run("store", 3'd4, 32'h200, 32'h1003);

    apply("misp_beats_bp", RSTN | MISP | BP, 32'h10, 0, 0, FF | FD, 3'd4, 32'h200, 32'h1003);
    apply("bp_dropped", RSTN, 0, 0, 0, 8'h00, 3'd4, 32'h200, 32'h1003);

    apply("load_beats_misp", RSTN | MISP | LDM, 0, 32'h300, 32'h55, FF | FD | FE, 3'd4, 32'h200, 32'h1003);
    apply("load_commit", RSTN, 0, 0, 0, EN, 3'd3, 32'h300, 32'h55);
    redirect_run("load", 3'd3, 32'h300, 32'h55);

    apply("bp_vs_ecall", RSTN | BP | ECALL, 32'h90, 0, 0, FF | FD, 3'd3, 32'h300, 32'h55);
    apply("bp_commit", RSTN, 0, 0, 0, EN, 3'd1, 32'h90, 0);
    redirect_run("bp", 3'd1, 32'h90, 0);

    apply("exc_mem_busy", RSTN | MEMB | ECALL, 32'hA0, 0, 0, SF | SD | SE | SM | FF | FD, 3'd1, 32'h90, 0);
    apply("drain1_2nd_exc", RSTN | MEMB | ILL, 32'hBB, 0, 0, SF | FF | FD, 3'd2, 32'hA0, 0);
    apply("drain2", RSTN | MEMB, 0, 0, 0, SF | FF | FD, 3'd2, 32'hA0, 0);
    apply("drain3", RSTN | MEMB, 0, 0, 0, SF | FF | FD, 3'd2, 32'hA0, 0);
    apply("drain4", RSTN, 0, 0, 0, SF | FF | FD, 3'd2, 32'hA0, 0);
    apply("drain_commit", RSTN, 0, 0, 0, EN, 3'd2, 32'hA0, 0);
    redirect_run("drain", 3'd2, 32'hA0, 0);

    apply("rst_exc", RSTN | MEMB | ILL, 32'hC0, 0, 0, SF | SD | SE | SM | FF | FD, 3'd2, 32'hA0, 0);
    apply("rst_drain", RSTN | MEMB, 0, 0, 0, SF | FF | FD, 3'd0, 32'hC0, 0);
    apply("rst_assert", 11'h000, 0, 0, 0, SF | FF | FD, 3'd0, 32'hC0, 0);
    apply("rst_after", RSTN, 0, 0, 0, 8'h00, 0, 0, 0);
    apply("rst_no_pulse", RSTN, 0, 0, 0, 8'h00, 0, 0, 0);

    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
